// File: rtl/truth_table_sweeper_if.sv
// Bundle between the sweeper and its environment: the start/done handshake, the
// expected table, the vector driven into the block under control and the results.
//
// Handshake: start is sampled only while the sweeper is idle and is consumed on the
// edge where it is seen high. busy is high from the next cycle until the sweep ends.
// done then pulses for one cycle with busy low. start seen while busy or during done
// is dropped and not queued. A requester that holds start high sees a new sweep begin
// in the idle cycle that follows done.
interface truth_table_sweeper_if;
  logic        start;
  logic [15:0] expected;
  logic        s;
  logic        a;
  logic        b;
  logic        c;
  logic        d;
  logic        busy;
  logic        done;
  logic [15:0] tt;
  logic        pass;
  logic [4:0]  mismatch_count;
  logic [3:0]  first_fail;
  logic        fail_valid;

  modport slave (
    input  start, expected, s,
    output a, b, c, d, busy, done, tt, pass, mismatch_count, first_fail, fail_valid
  );

  modport master (
    output start, expected, s,
    input  a, b, c, d, busy, done, tt, pass, mismatch_count, first_fail, fail_valid
  );
endinterface

// File: rtl/truth_table_sweeper.sv
// Walks a 4-input block through vectors 0..15, records its output into a truth table
// and grades that table against an expected one that is latched when start is accepted.
module truth_table_sweeper #(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  truth_table_sweeper_if.slave  bus,
  output logic [1:0]            state_dbg_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    APPLY  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_e;

  localparam logic [3:0] RELOAD = 4'(SETTLE_CYCLES - 1);

  state_e      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] exp_q, exp_d;
  logic [3:0]  vec_q, vec_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [15:0] tt_q, tt_d;
  logic        pass_q, pass_d;
  logic [4:0]  mc_q, mc_d;
  logic [3:0]  ff_q, ff_d;
  logic        fv_q, fv_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= 4'd0;
      cnt_q   <= 4'd0;
      exp_q   <= 16'd0;
      vec_q   <= 4'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      tt_q    <= 16'd0;
      pass_q  <= 1'b0;
      mc_q    <= 5'd0;
      ff_q    <= 4'd0;
      fv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      exp_q   <= exp_d;
      vec_q   <= vec_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      tt_q    <= tt_d;
      pass_q  <= pass_d;
      mc_q    <= mc_d;
      ff_q    <= ff_d;
      fv_q    <= fv_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    exp_d   = exp_q;
    tt_d    = tt_q;
    pass_d  = pass_q;
    mc_d    = mc_q;
    ff_d    = ff_q;
    fv_d    = fv_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          idx_d   = 4'd0;
          exp_d   = bus.expected;
          tt_d    = 16'd0;
          mc_d    = 5'd0;
          fv_d    = 1'b0;
          ff_d    = 4'd0;
          pass_d  = 1'b0;
          cnt_d   = RELOAD;
          state_d = APPLY;
        end
      end
      APPLY: begin
        if (cnt_q == 4'd0) begin
          state_d = SAMPLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      SAMPLE: begin
        tt_d[idx_q] = bus.s;
        if (bus.s != exp_q[idx_q]) begin
          mc_d = mc_q + 5'd1;
          if (!fv_q) begin
            ff_d = idx_q;
            fv_d = 1'b1;
          end
        end
        if (idx_q == 4'd15) begin
          state_d = DONE;
        end else begin
          idx_d   = idx_q + 4'd1;
          cnt_d   = RELOAD;
          state_d = APPLY;
        end
      end
      DONE: begin
        pass_d  = (mc_q == 5'd0);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered copies of what the next state will present.
    busy_d = (state_d == APPLY) || (state_d == SAMPLE);
    done_d = (state_d == DONE);
    vec_d  = busy_d ? idx_d : 4'd0;
  end

  assign {bus.a, bus.b, bus.c, bus.d} = vec_q;
  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign bus.tt             = tt_q;
  assign bus.pass           = pass_q;
  assign bus.mismatch_count = mc_q;
  assign bus.first_fail     = ff_q;
  assign bus.fail_valid     = fv_q;
  assign state_dbg_o        = state_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: two instances (settle 1 and 3) each driving a
// table-defined function, graded against a popcount/lowest-bit reference.
module tb_truth_table_sweeper;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_r;
  logic        sel;
  logic [15:0] exp_r;
  logic [15:0] fn_r;
  logic [1:0]  st0, st1;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  truth_table_sweeper_if if0 ();
  truth_table_sweeper_if if1 ();

  assign if0.start    = start_r & ~sel;
  assign if1.start    = start_r & sel;
  assign if0.expected = exp_r;
  assign if1.expected = exp_r;
  assign if0.s        = fn_r[{if0.a, if0.b, if0.c, if0.d}];
  assign if1.s        = fn_r[{if1.a, if1.b, if1.c, if1.d}];

  truth_table_sweeper #(.SETTLE_CYCLES(1)) dut0 (.clk(clk), .rst(rst), .bus(if0), .state_dbg_o(st0));
  truth_table_sweeper #(.SETTLE_CYCLES(3)) dut1 (.clk(clk), .rst(rst), .bus(if1), .state_dbg_o(st1));

  logic [3:0]  o_vec;
  logic        o_busy, o_done, o_pass, o_fv;
  logic [15:0] o_tt;
  logic [4:0]  o_mc;
  logic [3:0]  o_ff;

  assign o_vec  = sel ? {if1.a, if1.b, if1.c, if1.d} : {if0.a, if0.b, if0.c, if0.d};
  assign o_busy = sel ? if1.busy : if0.busy;
  assign o_done = sel ? if1.done : if0.done;
  assign o_pass = sel ? if1.pass : if0.pass;
  assign o_fv   = sel ? if1.fail_valid : if0.fail_valid;
  assign o_tt   = sel ? if1.tt : if0.tt;
  assign o_mc   = sel ? if1.mismatch_count : if0.mismatch_count;
  assign o_ff   = sel ? if1.first_fail : if0.first_fail;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset();
    check("rst_vec", 32'(o_vec), 0);
    check("rst_busy", 32'(o_busy), 0);
    check("rst_done", 32'(o_done), 0);
    check("rst_tt", 32'(o_tt), 0);
    check("rst_pass", 32'(o_pass), 0);
    check("rst_mc", 32'(o_mc), 0);
    check("rst_ff", 32'(o_ff), 0);
    check("rst_fv", 32'(o_fv), 0);
  endtask

  // Reference grading: mismatches are the set bits of fn^ex, first_fail the lowest one.
  task automatic check_results(input logic [15:0] fn, input logic [15:0] ex);
    logic [15:0] diff;
    int          mc;
    int          ff;
    diff = fn ^ ex;
    mc   = 0;
    ff   = -1;
    for (int i = 0; i < 16; i++) begin
      if (diff[i]) begin
        mc++;
        if (ff < 0) ff = i;
      end
    end
    check("res_tt", 32'(o_tt), 32'(fn));
    check("res_mc", 32'(o_mc), 32'(mc));
    check("res_fv", 32'(o_fv), (mc != 0) ? 1 : 0);
    check("res_ff", 32'(o_ff), (ff < 0) ? 0 : 32'(ff));
    check("res_pass", 32'(o_pass), (mc == 0) ? 1 : 0);
  endtask

  // One sweep on the selected instance. n counts cycles after start acceptance.
  task automatic sweep(input logic [15:0] fn, input logic [15:0] ex, input int settle,
                       input int pulse_n, input int chg_n, input int rst_n, input bit hold);
    int per;
    int done_n;
    per    = settle + 1;
    done_n = 1 + 16 * per;
    fn_r    = fn;
    exp_r   = ex;
    start_r = 1'b1;
    @(negedge clk);
    if (!hold) start_r = 1'b0;
    for (int n = 1; n <= done_n; n++) begin
      if (n == 1) begin
        check("clr_tt", 32'(o_tt), 0);
        check("clr_mc", 32'(o_mc), 0);
        check("clr_fv", 32'(o_fv), 0);
      end
      if (n < done_n) begin
        check("busy", 32'(o_busy), 1);
        check("vec", 32'(o_vec), 32'((n - 1) / per));
        check("done_early", 32'(o_done), 0);
      end else begin
        check("done", 32'(o_done), 1);
        check("busy_at_done", 32'(o_busy), 0);
      end
      if (n == pulse_n) start_r = 1'b1;
      else if (n == pulse_n + 1 && !hold) start_r = 1'b0;
      if (n == chg_n) exp_r = ~ex;
      if (n == rst_n) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset();
        return;
      end
      if (n < done_n) @(negedge clk);
    end
    @(negedge clk);
    check("done_once", 32'(o_done), 0);
    check("idle_busy", 32'(o_busy), 0);
    check("idle_vec", 32'(o_vec), 0);
    check_results(fn, ex);
    if (hold) begin
      @(negedge clk);
      check("held_restart", 32'(o_busy), 1);
      start_r = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_reset();
    end
  endtask

  initial begin
    logic [15:0] rfn;
    logic [15:0] rex;
    rst     = 1'b1;
    start_r = 1'b0;
    sel     = 1'b0;
    exp_r   = 16'h0;
    fn_r    = 16'h0;
    repeat (3) @(negedge clk);
    check_reset();
    sel = 1'b1;
    check_reset();
    sel = 1'b0;
    rst = 1'b0;
    @(negedge clk);

    // AND function, matching expectation
    sweep(16'h8000, 16'h8000, 1, -1, -1, -1, 1'b0);
    // XOR parity against a table that differs in vector 0
    sweep(16'h6996, 16'h6997, 1, -1, -1, -1, 1'b0);
    // constant one against all-zero expectation
    sweep(16'hFFFF, 16'h0000, 1, -1, -1, -1, 1'b0);
    // extra start pulse at vector 5 must be ignored
    sweep(16'h6996, 16'h8000, 1, 11, -1, -1, 1'b0);
    // reset at vector 9 aborts
    sweep(16'h6996, 16'h0000, 1, -1, -1, 19, 1'b0);
    @(negedge clk);
    // longer settle on the second instance
    sel = 1'b1;
    sweep(16'h8000, 16'h8001, 3, -1, -1, -1, 1'b0);
    sel = 1'b0;

    // expected changes mid-sweep, then results must stay put for 20 idle cycles
    sweep(16'h1234, 16'h1230, 1, -1, 5, -1, 1'b0);
    repeat (20) begin
      exp_r = 16'($urandom);
      @(negedge clk);
      check("sticky_busy", 32'(o_busy), 0);
      check_results(16'h1234, 16'h1230);
    end

    // start held high: new sweep right after the idle cycle
    sweep(16'h00FF, 16'h00FE, 1, -1, -1, -1, 1'b1);
    @(negedge clk);

    for (int k = 0; k < 6; k++) begin
      rfn = 16'($urandom);
      rex = ($urandom_range(0, 2) == 0) ? rfn : 16'($urandom);
      sel = 1'($urandom_range(0, 1));
      sweep(rfn, rex, sel ? 3 : 1, -1, -1, -1, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
